// File: rtl/max_pool_2x2_pkg.sv
// Shared definitions for the activation/pooling datapath: width convention and signed max.
package max_pool_2x2_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DATA_W = 2 * DEF_WIDTH;

    // smax works on a wide sign-extended operand so any stage width up to SMAX_W can share it.
    localparam int SMAX_W = 64;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_row_buf.sv
// Holds the horizontal pair maxima of an even row until the odd row below consumes them.
module pool_row_buf #(
    parameter int DEPTH  = 14,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // No reset: every entry is written during an even row before the odd row reads it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we_i && (wr_idx_i == IDX_W'(gi))) begin
                mem_q[gi] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pooling stage fed in raster order, no backpressure.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [2*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic signed [2*WIDTH-1:0] out_data,
    output logic                      frame_done
);

    localparam int DATA_W = 2 * WIDTH;
    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_done_q, frame_done_d;

    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] win_max;
    logic [DATA_W-1:0]        rb_rd_data;
    logic [IDX_W-1:0]         pair_idx;
    logic                     rb_we;
    logic                     odd_col, odd_row, last_col, last_row;

    assign odd_col  = col_q[0];
    assign odd_row  = row_q[0];
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    assign pair_idx = IDX_W'(col_q >> 1);

    assign hmax    = DATA_W'(smax(SMAX_W'(hold_q), SMAX_W'(in_data)));
    assign win_max = DATA_W'(smax(SMAX_W'(hmax), SMAX_W'($signed(rb_rd_data))));

    // Even rows write and odd rows read the same slot, never in the same cycle.
    pool_row_buf #(
        .DEPTH  (HALF_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_row_buf (
        .clk       (clk),
        .we_i      (rb_we),
        .wr_idx_i  (pair_idx),
        .wr_data_i (hmax),
        .rd_idx_i  (pair_idx),
        .rd_data_o (rb_rd_data)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        rb_we        = 1'b0;
        if (in_valid) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end
            if (!odd_col) begin
                hold_d = in_data;
            end else if (!odd_row) begin
                rb_we = 1'b1;
            end else begin
                out_data_d   = win_max;
                out_valid_d  = 1'b1;
                frame_done_d = last_col && last_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2 max-pooling stage (stride 2) that sits directly downstream of the ReLU activation register. It consumes one signed 2*WIDTH-bit activation per valid cycle in raster order, from row 0 column 0 to row IMG_H-1 column IMG_W-1. It emits one pooled value per 2×2 window, for (IMG_W/2)·(IMG_H/2) outputs per frame. A half-width row buffer holds the horizontal maxima of each even row until the matching odd row arrives.

## Interface
- WIDTH, 8, half data width; the sample width is 2*WIDTH.
- IMG_W, 28, frame width in pixels; must be even and ≥ 2.
- IMG_H, 28, frame height in pixels; must be even and ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data carries a pixel this cycle; no backpressure.
- in_data  in  2*WIDTH  signed two's-complement pixel.
- out_valid  out  1  out_data holds a pooled result this cycle (1-cycle pulse).
- out_data  out  2*WIDTH  signed max of the 2×2 window.
- frame_done  out  1  pulses high together with the final out_valid of a frame.

## Operation
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1.
  - Both advance only on in_valid. col wraps to 0 and increments row.
  - row wraps to 0 after the last pixel of a frame.
- Even col: in_data is captured into the pair register hold.
- Odd col: hmax = smax(hold, in_data).
  - Even row: row_buf[col>>1] <= hmax.
  - Odd row: out_data <= smax(hmax, row_buf[col>>1]) and out_valid <= 1.
- smax is a signed compare of the full 2*WIDTH bits. On a tie, the output is that value.
- No saturation or width change: out_data is bit-identical to one of the four window pixels.
- in_valid low: counters, hold and row_buf keep their values. out_valid drops to 0 and out_data holds its last value.
- frame_done = 1 in the same cycle as out_valid for window (IMG_H/2-1, IMG_W/2-1); otherwise 0.
- Back-to-back frames: pixel (0,0) of the next frame may arrive in the cycle after the last pixel, with no bubble.

## Timing
- Latency: out_valid rises exactly 1 cycle after the cycle that accepts the window's bottom-right pixel (odd row, odd col).
- Throughput: one pixel per cycle sustained. Outputs appear only during odd rows, at most one every 2 cycles.
- Reset (async assert, sync release): col=0, row=0, out_valid=0, out_data=0, frame_done=0, hold=0.
  - row_buf is not reset; every entry is written before it is read.
- Reset mid-frame: the partial frame is discarded and no output is produced for it. The next accepted pixel is (0,0).
- row_buf uses a combinational read and a synchronous write. Read and write never target the same row parity in one cycle, so no bypass is needed.

## Structure
- The shared package holds:
  - `DATA_W = 2*WIDTH` localparam convention.
  - The `smax` signed-max function, which the ReLU and pooling stages share.
- One sub-module, `pool_row_buf`: an IMG_W/2 × 2*WIDTH register array with write-enable and index ports. It is kept separate so it can later be swapped for a RAM macro.
- Top level contains: the counters, the hold register, the compare logic and the output register. Expected size is ~150 RTL lines.

## Test plan
- **Basic 4×4 frame** (IMG_W=IMG_H=4, continuous valid). Rows: [1 5 2 3], [4 0 7 6], [9 8 1 1], [2 3 4 10].
  - Outputs in order: 5, 7, 9, 10, each 1 cycle after its bottom-right pixel.
  - frame_done pulses with the value 10.
- **Negative values:** a window of 0xFFFD (-3), 0x0002, 0x8000, 0xFFFF → 0x0002. A window of all negatives -1, -5, -2, -8 → 0xFFFF.
- **Valid gaps:** the same 4×4 frame with in_valid randomly low ~50% → identical output sequence. out_valid is never high in a cycle that does not follow an accepted bottom-right pixel.
- **Back-to-back frames:** two 4×4 frames with no bubble. The second frame, all 0x0001, → 1, 1, 1, 1. frame_done pulses twice, 4 outputs apart.
- **Reset mid-frame:** assert rst_n low after 6 pixels → all outputs 0 at once. After release, a full frame gives the correct 4 outputs and nothing from the discarded partial frame.
- **Equal values / tie:** a window of all 0x7FFF → 0x7FFF. Check at IMG_W=28, IMG_H=28 → 196 outputs with exactly one frame_done.
